// File: rtl/fifo_byte_packer.sv
// Byte-to-word packer feeding a shared-port FIFO: fills 32-bit words little-endian,
// holds a completed word until the FIFO accepts it, and flags words popped on the read side.
module fifo_byte_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESETH,
    input  logic             IN_VALID,
    input  logic [7:0]       IN_DATA,
    input  logic             IN_LAST,
    output logic             IN_READY,
    input  logic             FIFO_FULL,
    input  logic             FIFO_EMPTY,
    output logic             WRH_RDL,
    output logic [31:0]      FIFO_DIN,
    output logic             RD_VALID,
    output logic [CNT_W-1:0] WORD_CNT,
    output logic [CNT_W-1:0] STALL_CNT
);

    typedef enum logic {S_FILL, S_PEND} state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_byte_idx, w_byte_idx_nxt;
    logic [31:0]        r_word, w_word_nxt;
    logic               r_rd_valid;
    logic [CNT_W-1:0]   r_word_cnt, r_stall_cnt;
    logic               w_done, w_wr, w_stall;

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_idx_nxt = r_byte_idx;
        w_word_nxt     = r_word;
        w_done         = 1'b0;
        w_wr           = 1'b0;
        w_stall        = 1'b0;
        case (r_state)
            S_FILL: begin
                if (IN_VALID) begin
                    w_done = (r_byte_idx == 2'd3) || IN_LAST;
                    // Lanes above the current byte are padded only when the word closes early.
                    for (int i = 0; i < 4; i++) begin
                        if (2'(i) == r_byte_idx)
                            w_word_nxt[8*i +: 8] = IN_DATA;
                        else if (w_done && (2'(i) > r_byte_idx))
                            w_word_nxt[8*i +: 8] = PAD_BYTE;
                    end
                    w_byte_idx_nxt = w_done ? 2'd0 : r_byte_idx + 2'd1;
                    if (w_done)
                        w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (!FIFO_FULL) begin
                    w_wr        = 1'b1;
                    w_state_nxt = S_FILL;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESETH) begin
            r_state     <= S_FILL;
            r_byte_idx  <= 2'd0;
            r_word      <= 32'd0;
            r_rd_valid  <= 1'b0;
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_word     <= w_word_nxt;
            // The FIFO registers DATAOUT on the same edge it pops, so this lines up with it.
            r_rd_valid <= !WRH_RDL && !FIFO_EMPTY;
            if (w_wr)
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign IN_READY  = (r_state == S_FILL);
    assign WRH_RDL   = (r_state == S_PEND);
    assign FIFO_DIN  = r_word;
    assign RD_VALID  = r_rd_valid;
    assign WORD_CNT  = r_word_cnt;
    assign STALL_CNT = r_stall_cnt;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer with a behavioural 32x32 shared-port FIFO attached.
module tb_fifo_byte_packer;

    logic        CLK = 1'b0;
    logic        RESETH = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [7:0]  IN_DATA = 8'h00;
    logic        IN_LAST = 1'b0;
    logic        IN_READY;
    logic        FIFO_FULL, FIFO_EMPTY;
    logic        WRH_RDL;
    logic [31:0] FIFO_DIN;
    logic        RD_VALID;
    logic [15:0] WORD_CNT, STALL_CNT;

    int checks = 0;
    int errors = 0;

    fifo_byte_packer #(.PAD_BYTE(8'h00), .CNT_W(16)) dut (
        .CLK(CLK), .RESETH(RESETH),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .IN_READY(IN_READY),
        .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY), .WRH_RDL(WRH_RDL),
        .FIFO_DIN(FIFO_DIN), .RD_VALID(RD_VALID), .WORD_CNT(WORD_CNT), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    // Shared-port FIFO model: write when WRH_RDL and not full, otherwise pop when not empty.
    logic [31:0] mem [0:31];
    logic [4:0]  wp = 5'd0, rp = 5'd0;
    int          cnt = 0;
    int          n_wr = 0;
    logic [31:0] dout = 32'd0;
    logic        force_full = 1'b0;
    logic        rnd_full = 1'b0;

    assign FIFO_FULL  = (cnt == 32) || force_full;
    assign FIFO_EMPTY = (cnt == 0);

    always @(posedge CLK) begin
        if (RESETH) begin
            cnt <= 0; wp <= 5'd0; rp <= 5'd0; dout <= 32'd0;
        end else if (WRH_RDL) begin
            if (!FIFO_FULL) begin
                mem[wp] <= FIFO_DIN; wp <= wp + 5'd1; cnt <= cnt + 1; n_wr <= n_wr + 1;
            end
        end else if (!FIFO_EMPTY) begin
            dout <= mem[rp]; rp <= rp + 5'd1; cnt <= cnt - 1;
        end
    end

    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];

    always @(negedge CLK) if (!RESETH && RD_VALID) got_q.push_back(dout);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rnd_full) force_full = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        bit ok = 0;
        IN_VALID = 1'b1; IN_DATA = d; IN_LAST = last;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (IN_READY) ok = 1;
            tick();
        end
        IN_VALID = 1'b0; IN_LAST = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $error("FAIL accept_timeout byte %02h observed not-accepted expected accepted", d);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (!WRH_RDL) ok = 1; else tick();
        end
        if (!ok) begin
            checks++; errors++;
            $error("FAIL write_timeout observed WRH_RDL=1 expected 0");
        end
    endtask

    initial begin
        int n0;
        logic [31:0] w;

        // Reset state
        RESETH = 1'b1; tick(); tick();
        RESETH = 1'b0; tick();
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_wrh_rdl", WRH_RDL, 0);
        chk("rst_fifo_din", FIFO_DIN, 0);
        chk("rst_rd_valid", RD_VALID, 0);
        chk("rst_word_cnt", WORD_CNT, 0);
        chk("rst_stall_cnt", STALL_CNT, 0);

        // Full word 11,22,33,44
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        chk("w1_din", FIFO_DIN, 32'h44332211);
        chk("w1_wrh", WRH_RDL, 1);
        chk("w1_ready", IN_READY, 0);
        tick();
        chk("w1_word_cnt", WORD_CNT, 1);
        chk("w1_ready_after", IN_READY, 1);

        // Early flush with IN_LAST, then IN_LAST without IN_VALID is ignored
        send_byte(8'hAA, 0); send_byte(8'hBB, 1);
        chk("flush_din", FIFO_DIN, 32'h0000BBAA);
        chk("flush_wrh", WRH_RDL, 1);
        tick();
        chk("flush_word_cnt", WORD_CNT, 2);
        IN_LAST = 1'b1; tick(); IN_LAST = 1'b0;
        chk("last_novalid_wrh", WRH_RDL, 0);
        send_byte(8'hCC, 0); send_byte(8'hDD, 1);
        chk("lane0_after_flush", FIFO_DIN, 32'h0000DDCC);
        tick();
        chk("flush2_word_cnt", WORD_CNT, 3);

        // Stall under FULL for 7 cycles
        tick(); tick(); tick();
        force_full = 1'b1;
        send_word(32'h04030201);
        chk("stall_pend", WRH_RDL, 1);
        chk("stall_cnt0", STALL_CNT, 0);
        n0 = n_wr;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("stall_ready", IN_READY, 0);
        end
        chk("stall_cnt7", STALL_CNT, 7);
        chk("stall_nowrite", n_wr, n0);
        force_full = 1'b0;
        tick();
        chk("stall_one_write", n_wr, n0 + 1);
        chk("stall_word_cnt", WORD_CNT, 4);
        chk("stall_cnt_hold", STALL_CNT, 7);

        // Three words then drain
        tick(); tick(); tick();
        got_q.delete();
        send_word(32'h13121110); send_word(32'h23222120); send_word(32'h33323130);
        wait_idle();
        for (int k = 0; k < 5; k++) tick();
        chk("drain_pulses", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("drain_w0", got_q[0], 32'h13121110);
            chk("drain_w1", got_q[1], 32'h23222120);
            chk("drain_w2", got_q[2], 32'h33323130);
        end
        chk("drain_word_cnt", WORD_CNT, 7);

        // Reset while a word is pending
        send_word(32'h5A5A5A5A);
        chk("rstpend_wrh", WRH_RDL, 1);
        n0 = n_wr;
        RESETH = 1'b1; tick(); tick();
        RESETH = 1'b0; tick();
        chk("rstpend_nowrite", n_wr, n0);
        chk("rstpend_word_cnt", WORD_CNT, 0);
        chk("rstpend_stall_cnt", STALL_CNT, 0);
        chk("rstpend_ready", IN_READY, 1);
        send_byte(8'h55, 1);
        chk("rstpend_lane0", FIFO_DIN, 32'h00000055);
        wait_idle();

        // Reset mid-word drops the partial bytes
        send_byte(8'h66, 0); send_byte(8'h77, 0);
        RESETH = 1'b1; tick();
        RESETH = 1'b0; tick();
        send_byte(8'h88, 1);
        chk("rstmid_lane0", FIFO_DIN, 32'h00000088);
        wait_idle();

        // 32 words with random FULL stalls
        RESETH = 1'b1; tick();
        RESETH = 1'b0; tick();
        got_q.delete(); exp_q.delete();
        rnd_full = 1'b1;
        for (int i = 0; i < 32; i++) begin
            w = $urandom;
            exp_q.push_back(w);
            send_word(w);
        end
        wait_idle();
        rnd_full = 1'b0; force_full = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("bulk_word_cnt", WORD_CNT, 32);
        chk("bulk_read_count", got_q.size(), 32);
        if (got_q.size() == 32)
            for (int i = 0; i < 32; i++) chk($sformatf("bulk_w%0d", i), got_q[i], exp_q[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
